// File: rtl/difftest_arch_reg_tracker.sv
// Architectural register shadow for difftest: two commit write ports update a
// 32-entry register snapshot, alongside a retired-instruction counter and a snapshot strobe.
module difftest_arch_reg_tracker #(
  parameter int              XLEN    = 64,
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic            io_clock,
  input  logic            io_reset,
  input  logic [7:0]      io_coreid_in,
  input  logic            io_wb0_valid,
  input  logic [4:0]      io_wb0_addr,
  input  logic [XLEN-1:0] io_wb0_data,
  input  logic            io_wb1_valid,
  input  logic [4:0]      io_wb1_addr,
  input  logic [XLEN-1:0] io_wb1_data,
  input  logic [1:0]      io_commit_cnt,
  output logic [7:0]      io_coreid,
  output logic [XLEN-1:0] io_gpr_0,
  output logic [XLEN-1:0] io_gpr_1,
  output logic [XLEN-1:0] io_gpr_2,
  output logic [XLEN-1:0] io_gpr_3,
  output logic [XLEN-1:0] io_gpr_4,
  output logic [XLEN-1:0] io_gpr_5,
  output logic [XLEN-1:0] io_gpr_6,
  output logic [XLEN-1:0] io_gpr_7,
  output logic [XLEN-1:0] io_gpr_8,
  output logic [XLEN-1:0] io_gpr_9,
  output logic [XLEN-1:0] io_gpr_10,
  output logic [XLEN-1:0] io_gpr_11,
  output logic [XLEN-1:0] io_gpr_12,
  output logic [XLEN-1:0] io_gpr_13,
  output logic [XLEN-1:0] io_gpr_14,
  output logic [XLEN-1:0] io_gpr_15,
  output logic [XLEN-1:0] io_gpr_16,
  output logic [XLEN-1:0] io_gpr_17,
  output logic [XLEN-1:0] io_gpr_18,
  output logic [XLEN-1:0] io_gpr_19,
  output logic [XLEN-1:0] io_gpr_20,
  output logic [XLEN-1:0] io_gpr_21,
  output logic [XLEN-1:0] io_gpr_22,
  output logic [XLEN-1:0] io_gpr_23,
  output logic [XLEN-1:0] io_gpr_24,
  output logic [XLEN-1:0] io_gpr_25,
  output logic [XLEN-1:0] io_gpr_26,
  output logic [XLEN-1:0] io_gpr_27,
  output logic [XLEN-1:0] io_gpr_28,
  output logic [XLEN-1:0] io_gpr_29,
  output logic [XLEN-1:0] io_gpr_30,
  output logic [XLEN-1:0] io_gpr_31,
  output logic            io_snap_valid,
  output logic [63:0]     io_instr_cnt
);

  // Write ports are valid-only: there is no ready, so every write presented
  // with valid high outside reset is taken on that rising edge.
  logic [XLEN-1:0] gpr_q [1:31];
  logic [63:0]     instr_cnt_q;
  logic            snap_q;
  logic [7:0]      coreid_q;
  logic [1:0]      commit_eff;

  // An illegal count of 3 is clamped so the counter still advances sanely.
  assign commit_eff = (io_commit_cnt == 2'd3) ? 2'd2 : io_commit_cnt;

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      for (int i = 1; i < 32; i++) gpr_q[i] <= RST_VAL;
      instr_cnt_q <= '0;
      snap_q      <= 1'b0;
      coreid_q    <= '0;
    end else begin
      assert (io_commit_cnt != 2'd3)
        else $error("difftest_arch_reg_tracker: illegal io_commit_cnt of 3");
      // Port 1 is the younger commit, so it takes priority on an address clash.
      for (int i = 1; i < 32; i++) begin
        if (io_wb1_valid && io_wb1_addr == 5'(i)) gpr_q[i] <= io_wb1_data;
        else if (io_wb0_valid && io_wb0_addr == 5'(i)) gpr_q[i] <= io_wb0_data;
      end
      instr_cnt_q <= instr_cnt_q + 64'(commit_eff);
      snap_q      <= (io_commit_cnt != 2'd0);
      coreid_q    <= io_coreid_in;
    end
  end

  assign io_coreid     = coreid_q;
  assign io_snap_valid = snap_q;
  assign io_instr_cnt  = instr_cnt_q;

  assign io_gpr_0  = '0;
  assign io_gpr_1  = gpr_q[1];
  assign io_gpr_2  = gpr_q[2];
  assign io_gpr_3  = gpr_q[3];
  assign io_gpr_4  = gpr_q[4];
  assign io_gpr_5  = gpr_q[5];
  assign io_gpr_6  = gpr_q[6];
  assign io_gpr_7  = gpr_q[7];
  assign io_gpr_8  = gpr_q[8];
  assign io_gpr_9  = gpr_q[9];
  assign io_gpr_10 = gpr_q[10];
  assign io_gpr_11 = gpr_q[11];
  assign io_gpr_12 = gpr_q[12];
  assign io_gpr_13 = gpr_q[13];
  assign io_gpr_14 = gpr_q[14];
  assign io_gpr_15 = gpr_q[15];
  assign io_gpr_16 = gpr_q[16];
  assign io_gpr_17 = gpr_q[17];
  assign io_gpr_18 = gpr_q[18];
  assign io_gpr_19 = gpr_q[19];
  assign io_gpr_20 = gpr_q[20];
  assign io_gpr_21 = gpr_q[21];
  assign io_gpr_22 = gpr_q[22];
  assign io_gpr_23 = gpr_q[23];
  assign io_gpr_24 = gpr_q[24];
  assign io_gpr_25 = gpr_q[25];
  assign io_gpr_26 = gpr_q[26];
  assign io_gpr_27 = gpr_q[27];
  assign io_gpr_28 = gpr_q[28];
  assign io_gpr_29 = gpr_q[29];
  assign io_gpr_30 = gpr_q[30];
  assign io_gpr_31 = gpr_q[31];

endmodule

// File: tb/tb_difftest_arch_reg_tracker.sv
// Directed and random checks of the architectural register tracker against a
// bench-side register model and an expected-result queue.
module tb_difftest_arch_reg_tracker;

  localparam int          XLEN = 64;
  localparam logic [63:0] RSTV = 64'h5A5A_0000_C3C3_0001;

  logic        io_clock = 1'b0;
  logic        io_reset = 1'b1;
  logic [7:0]  io_coreid_in = '0;
  logic        io_wb0_valid = 1'b0, io_wb1_valid = 1'b0;
  logic [4:0]  io_wb0_addr = '0, io_wb1_addr = '0;
  logic [63:0] io_wb0_data = '0, io_wb1_data = '0;
  logic [1:0]  io_commit_cnt = '0;
  logic [7:0]  io_coreid;
  logic        io_snap_valid;
  logic [63:0] io_instr_cnt;
  logic [63:0] gpr [32];

  logic [63:0] ref_gpr [32];
  logic [63:0] ref_cnt;
  logic [63:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  difftest_arch_reg_tracker #(.XLEN(XLEN), .RST_VAL(RSTV)) dut (
    .io_clock(io_clock), .io_reset(io_reset), .io_coreid_in(io_coreid_in),
    .io_wb0_valid(io_wb0_valid), .io_wb0_addr(io_wb0_addr), .io_wb0_data(io_wb0_data),
    .io_wb1_valid(io_wb1_valid), .io_wb1_addr(io_wb1_addr), .io_wb1_data(io_wb1_data),
    .io_commit_cnt(io_commit_cnt), .io_coreid(io_coreid),
    .io_gpr_0(gpr[0]),   .io_gpr_1(gpr[1]),   .io_gpr_2(gpr[2]),   .io_gpr_3(gpr[3]),
    .io_gpr_4(gpr[4]),   .io_gpr_5(gpr[5]),   .io_gpr_6(gpr[6]),   .io_gpr_7(gpr[7]),
    .io_gpr_8(gpr[8]),   .io_gpr_9(gpr[9]),   .io_gpr_10(gpr[10]), .io_gpr_11(gpr[11]),
    .io_gpr_12(gpr[12]), .io_gpr_13(gpr[13]), .io_gpr_14(gpr[14]), .io_gpr_15(gpr[15]),
    .io_gpr_16(gpr[16]), .io_gpr_17(gpr[17]), .io_gpr_18(gpr[18]), .io_gpr_19(gpr[19]),
    .io_gpr_20(gpr[20]), .io_gpr_21(gpr[21]), .io_gpr_22(gpr[22]), .io_gpr_23(gpr[23]),
    .io_gpr_24(gpr[24]), .io_gpr_25(gpr[25]), .io_gpr_26(gpr[26]), .io_gpr_27(gpr[27]),
    .io_gpr_28(gpr[28]), .io_gpr_29(gpr[29]), .io_gpr_30(gpr[30]), .io_gpr_31(gpr[31]),
    .io_snap_valid(io_snap_valid), .io_instr_cnt(io_instr_cnt)
  );

  // Clock / reset
  always #5 io_clock = ~io_clock;

  task automatic model_reset();
    ref_gpr[0] = '0;
    for (int i = 1; i < 32; i++) ref_gpr[i] = RSTV;
    ref_cnt = '0;
    exp_q.delete();
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_gprs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_gpr%0d", tag, i), gpr[i], ref_gpr[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt"}, io_instr_cnt, 64'd0);
    check({tag, "_snap"}, {63'd0, io_snap_valid}, 64'd0);
    check({tag, "_core"}, {56'd0, io_coreid}, 64'd0);
    check_gprs(tag);
  endtask

  // Driver: called at a falling edge, returns at the next falling edge.
  task automatic step(input string tag,
                      input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic [1:0] cnt, input logic [7:0] core);
    logic [63:0] e_cnt, e_snap, e_core;
    io_wb0_valid = v0; io_wb0_addr = a0; io_wb0_data = d0;
    io_wb1_valid = v1; io_wb1_addr = a1; io_wb1_data = d1;
    io_commit_cnt = cnt; io_coreid_in = core;
    if (v0 && a0 != 5'd0) ref_gpr[a0] = d0;
    if (v1 && a1 != 5'd0) ref_gpr[a1] = d1;
    ref_cnt = ref_cnt + 64'(cnt);
    exp_q.push_back(ref_cnt);
    exp_q.push_back({63'd0, cnt != 2'd0});
    exp_q.push_back({56'd0, core});
    @(posedge io_clock);
    #1;
    e_cnt = exp_q.pop_front();
    e_snap = exp_q.pop_front();
    e_core = exp_q.pop_front();
    check({tag, "_cnt"}, io_instr_cnt, e_cnt);
    check({tag, "_snap"}, {63'd0, io_snap_valid}, e_snap);
    check({tag, "_core"}, {56'd0, io_coreid}, e_core);
    check_gprs(tag);
    @(negedge io_clock);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge io_clock);
    check_reset_outputs("por");
    io_reset = 1'b0;

    step("idle",   0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 2'd0, 8'h3C);
    step("single", 1, 5'd3, 64'hDEAD_BEEF, 0, 5'd0, 64'd0, 2'd1, 8'h3C);
    step("clash",  1, 5'd7, 64'h11, 1, 5'd7, 64'h22, 2'd2, 8'h41);
    step("dual",   1, 5'd5, 64'hAAAA_1234, 1, 5'd9, 64'hBBBB_5678, 2'd2, 8'h42);
    step("x0",     0, 5'd0, 64'd0, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 8'h43);
    step("x0both", 1, 5'd0, 64'h1, 1, 5'd0, 64'h2, 2'd2, 8'h44);
    step("novld",  0, 5'd4, 64'h1357, 0, 5'd6, 64'h2468, 2'd0, 8'h45);
    step("wr31",   1, 5'd31, 64'h8000_0000_0000_0001, 0, 5'd1, 64'h9, 2'd1, 8'h46);

    // Asynchronous reset with a write to x5 pending on port 0.
    io_wb0_valid = 1'b1; io_wb0_addr = 5'd5; io_wb0_data = 64'hCAFE_F00D;
    io_commit_cnt = 2'd1; io_coreid_in = 8'h77;
    #2;
    io_reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("arst");
    @(posedge io_clock);
    #1;
    check_reset_outputs("arst_edge");
    @(negedge io_clock);
    io_reset = 1'b0;
    step("post_rst", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 2'd0, 8'h00);
    step("post_rst1", 0, 5'd5, 64'd0, 1, 5'd2, 64'h55, 2'd1, 8'h01);

    // Counter wrap via backdoor preload.
    dut.instr_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    ref_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step("wrap",   0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 2'd2, 8'h10);
    step("wrap2",  0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 2'd1, 8'h11);

    for (int n = 0; n < 10000; n++) begin
      step("rand",
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/difftest_arch_reg_tracker.md
DIFFTEST_ARCH_REG_TRACKER -- requirements
Module: difftest_arch_reg_tracker

Interface
REQ-001 Parameter XLEN, default 64: register data width.
REQ-002 Parameter RST_VAL, default 0: value loaded into every architectural register on reset.
REQ-003 io_clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 io_reset  input  1: asynchronous reset, active-high.
REQ-005 io_coreid_in  input  8: hart id, registered and forwarded.
REQ-006 io_wb0_valid  input  1: older commit-port write enable.
REQ-007 io_wb0_addr  input  5: older commit-port destination register.
REQ-008 io_wb0_data  input  XLEN: older commit-port write data.
REQ-009 io_wb1_valid, io_wb1_addr, io_wb1_data  input  1/5/XLEN: younger commit port, same meaning as port 0.
REQ-010 io_commit_cnt  input  2: number of instructions retired this cycle (0..2), including those without a register write.
REQ-011 io_coreid  output  8: registered hart id, to the architectural-register-state consumer.
REQ-012 io_gpr_0 .. io_gpr_31  output  XLEN each: architectural register snapshot, to the architectural-register-state consumer.
REQ-013 io_snap_valid  output  1: pulses high for one cycle after any cycle with io_commit_cnt != 0.
REQ-014 io_instr_cnt  output  64: running count of retired instructions.

Function
REQ-015 Shadow file of 32 registers x XLEN bits; io_gpr_N driven directly from register N, with no combinational path from the write ports.
REQ-016 Write latency of 1 cycle: a valid write sampled at edge N is visible on io_gpr at edge N, i.e. observable in the cycle after it was presented.
REQ-017 Writes with addr == 0 are discarded; io_gpr_0 is 0 at all times, including directly after reset regardless of RST_VAL.
REQ-018 Both ports valid with different addrs: both registers update in the same cycle.
REQ-019 Both ports valid with equal non-zero addr: port 1 (younger) data wins; port 0 data is dropped.
REQ-020 A port with valid low never modifies state, whatever its addr and data.
REQ-021 io_instr_cnt increments by io_commit_cnt each cycle and wraps modulo 2^64 without saturation.
REQ-022 io_commit_cnt == 3 is illegal; the block treats it as 2 and asserts a simulation-only error message.
REQ-023 io_snap_valid is the registered value of (io_commit_cnt != 0), giving 1-cycle latency aligned with the io_gpr update.
REQ-024 io_coreid is io_coreid_in delayed by one register stage.
REQ-025 The block has no backpressure; every presented write is accepted in the cycle it is presented.

Reset
REQ-026 While io_reset is high: io_gpr_1..31 = RST_VAL, io_gpr_0 = 0, io_instr_cnt = 0, io_snap_valid = 0, io_coreid = 0.
REQ-027 Assertion of io_reset takes effect immediately without waiting for a clock edge.
REQ-028 Writes and commits presented in any cycle with io_reset high are lost.
REQ-029 Normal operation resumes on the first rising edge after io_reset deasserts.

Verification
REQ-030 Reset check: reset asserted mid-run with a pending wb0 write to x5 -> all outputs at reset values with no clock edge; x5 = RST_VAL after release.
REQ-031 Single write: wb0 x3 = 0xDEAD_BEEF, commit_cnt = 1 -> io_gpr_3 = 0xDEADBEEF and io_snap_valid = 1 in the next cycle; io_instr_cnt = 1.
REQ-032 Port collision: wb0 and wb1 both x7, data 0x11 and 0x22, commit_cnt = 2 -> io_gpr_7 = 0x22, io_instr_cnt += 2.
REQ-033 x0 write: wb1 x0 = 0xFFFF_FFFF_FFFF_FFFF -> io_gpr_0 stays 0; no other register changes.
REQ-034 Counter wrap: io_instr_cnt forced to 2^64-1 via prior commits or backdoor, then commit_cnt = 2 -> io_instr_cnt = 1.
REQ-035 Random regression: 10k cycles of random writes and commits, with a reference model compared against io_gpr and io_instr_cnt every cycle, and zero mismatches.
